// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out shifter with ready/valid accept and a done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);
`ifdef PISO_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d, word, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sout_q, sout_d, sout_valid_q, sout_valid_d, done_q, done_d;
  logic last, accept, running;
`ifdef PISO_PARITY_EN
  // Parity sits at the far end of the frame word so it leaves after the data bits.
  assign word = MSB_FIRST ? {din, ^din} : {^din, din};
`else
  assign word = din;
`endif
  assign shifted    = MSB_FIRST ? {shreg_q[FW-2:0], 1'b0} : {1'b0, shreg_q[FW-1:1]};
  assign last       = (state_q == SHIFT) && (cnt_q == CW'(FW - 1));
  assign running    = (state_q == SHIFT) && !last;
  assign din_ready  = (state_q == IDLE) || last;
  assign accept     = din_valid && din_ready;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = sout_valid_q;
  assign done       = done_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = accept ? SHIFT : last ? IDLE : state_q;
  end
  // sout mirrors the output end of the next register value, so it is a flop, not a mux.
  always_comb begin
    shreg_d      = accept ? word : running ? shifted : '0;
    cnt_d        = accept ? '0 : running ? cnt_q + 1'b1 : '0;
    sout_d       = MSB_FIRST ? shreg_d[FW-1] : shreg_d[0];
    sout_valid_d = (state_d == SHIFT);
    done_d       = (state_d == SHIFT) && (cnt_d == CW'(FW - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end
endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed checks of an MSB-first and an LSB-first instance fed the same words.
module tb_piso_shift_reg;
`ifdef PISO_PARITY_EN
  localparam int FL = 5;
  localparam logic [4:0] M1011 = 5'b10111, L1011 = 5'b11011;
  localparam logic [4:0] M0110 = 5'b01100, L0110 = 5'b01100;
  localparam logic [4:0] M1000 = 5'b10001, L1000 = 5'b00011;
  localparam logic [4:0] M1111 = 5'b11110, L1111 = 5'b11110;
  localparam logic [4:0] M0001 = 5'b00011, L0001 = 5'b10001;
`else
  localparam int FL = 4;
  localparam logic [3:0] M1011 = 4'b1011, L1011 = 4'b1101;
  localparam logic [3:0] M0110 = 4'b0110, L0110 = 4'b0110;
  localparam logic [3:0] M1000 = 4'b1000, L1000 = 4'b0001;
  localparam logic [3:0] M1111 = 4'b1111, L1111 = 4'b1111;
  localparam logic [3:0] M0001 = 4'b0001, L0001 = 4'b1000;
`endif
  logic clk = 1'b0;
  logic rst, din_valid, din_ready, sout, sout_valid, busy, done;
  logic din_ready_l, sout_l, sout_valid_l, busy_l, done_l;
  logic [3:0] din;
  int n_chk = 0;
  int n_fail = 0;
  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );
  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .busy(busy_l), .done(done_l)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_sout"}, sout, 0);
    check({tag, "_valid"}, sout_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, din_ready, 1);
    check({tag, "_valid_lsb"}, sout_valid_l, 0);
    check({tag, "_busy_lsb"}, busy_l, 0);
  endtask
  task automatic send(input logic [3:0] w, input bit hold, input logic [3:0] nxt);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    check("accept_ready", din_ready, 1);
    @(posedge clk);
    #1;
    if (hold) din = nxt;
    else din_valid = 1'b0;
  endtask
  task automatic run(input logic [15:0] em, input logic [15:0] el, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check($sformatf("sout_b%0d", k), sout, em[n-k]);
      check($sformatf("sout_lsb_b%0d", k), sout_l, el[n-k]);
      check($sformatf("valid_b%0d", k), sout_valid, 1);
      check($sformatf("busy_b%0d", k), busy, 1);
      check($sformatf("done_b%0d", k), done, (k % FL) == 0);
      check($sformatf("done_lsb_b%0d", k), done_l, (k % FL) == 0);
      check($sformatf("ready_b%0d", k), din_ready, (k % FL) == 0);
      @(posedge clk);
      #1;
      if (k == FL) din_valid = 1'b0;
    end
    @(negedge clk);
    check_idle("after");
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    din = '0;
    din_valid = 1'b0;
    #1 rst = 1'b1;
    #3 check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
    send(4'b1011, 0, 4'b0000);
    run({12'b0, M1011}, {12'b0, L1011}, FL);
    send(4'b0110, 0, 4'b0000);
    run({12'b0, M0110}, {12'b0, L0110}, FL);
    send(4'b1011, 1, 4'b0110);
    run({M1011, M0110}, {L1011, L0110}, 2 * FL);
    send(4'b1000, 1, 4'b1111);
    run({M1000, M1111}, {L1000, L1111}, 2 * FL);
    send(4'b1011, 0, 4'b0000);
    @(negedge clk);
    check("rst_pre_b1", sout, 1);
    @(negedge clk);
    check("rst_pre_b2", sout, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_sout", sout, 0);
    check("rst_async_valid", sout_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_valid_lsb", sout_valid_l, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    send(4'b0001, 0, 4'b0000);
    run({12'b0, M0001}, {12'b0, L0001}, FL);
    repeat (2) @(negedge clk);
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
